// File: rtl/ura_hazard_scoreboard_if.sv
// Signal bundle between the D stage (master) and the URA hazard scoreboard (slave).
interface ura_hazard_scoreboard_if #(
  parameter int NUM_READ = 2,
  parameter int TW       = 3,
  parameter int SELW     = 2
);
  logic                     issue_valid;
  logic [6:0]               issue_dst;
  logic [TW-1:0]            issue_tnew;
  logic                     issue_md;
  logic                     issue_md_start;
  logic                     issue_md_div;
  logic [NUM_READ-1:0]      rd_valid;
  logic [NUM_READ*7-1:0]    rd_ura;
  logic [NUM_READ*TW-1:0]   rd_tuse;
  logic                     flush;
  logic                     stall;
  logic [NUM_READ*SELW-1:0] fwd_sel;
  logic                     md_busy;

  modport master (
    output issue_valid, issue_dst, issue_tnew, issue_md, issue_md_start, issue_md_div,
    output rd_valid, rd_ura, rd_tuse, flush,
    input  stall, fwd_sel, md_busy
  );

  modport slave (
    input  issue_valid, issue_dst, issue_tnew, issue_md, issue_md_start, issue_md_div,
    input  rd_valid, rd_ura, rd_tuse, flush,
    output stall, fwd_sel, md_busy
  );
endinterface

// File: rtl/ura_hazard_scoreboard.sv
// D-stage hazard/forwarding unit keyed on 7-bit URAs: tracks in-flight writers
// with remaining latency, plus the multiply/divide busy window.
module ura_hazard_scoreboard #(
  parameter int NUM_READ = 2,
  parameter int DEPTH    = 3,
  parameter int TW       = 3,
  parameter int MUL_LAT  = 5,
  parameter int DIV_LAT  = 10,
  parameter int SELW     = 2
) (
  input logic                    clk,
  input logic                    reset,
  ura_hazard_scoreboard_if.slave sb
);
  localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int MDW     = $clog2(MAX_LAT + 1);

  logic          r_valid [1:DEPTH];
  logic [6:0]    r_ura   [1:DEPTH];
  logic [TW-1:0] r_tnew  [1:DEPTH];
  logic [MDW-1:0] r_md_cnt;

  logic [NUM_READ-1:0] w_port_hz;
  logic [NUM_READ-1:0] w_port_hilo;
  logic                w_md_busy;
  logic                w_md_hz;
  logic                w_stall;
  logic                w_accept;
  logic                w_load;

  generate
    for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_port
      logic [6:0]      w_ura;
      logic [TW-1:0]   w_tuse;
      logic            w_hz;
      logic [SELW-1:0] w_sel;

      assign w_ura  = sb.rd_ura[gi*7 +: 7];
      assign w_tuse = sb.rd_tuse[gi*TW +: TW];

      // Walk oldest to youngest so the lowest matching stage has the final say.
      always_comb begin
        w_hz  = 1'b0;
        w_sel = '0;
        for (int k = DEPTH; k >= 1; k--) begin
          if (sb.rd_valid[gi] && r_valid[k] && (r_ura[k] == w_ura) && (w_ura != 7'd0)) begin
            w_hz  = (r_tnew[k] > w_tuse);
            w_sel = (!(r_tnew[k] > w_tuse) && (r_tnew[k] == '0)) ? SELW'(k) : '0;
          end
        end
      end

      assign w_port_hz[gi]   = w_hz;
      assign w_port_hilo[gi] = sb.rd_valid[gi] & (w_ura[6:5] == 2'b10);
      assign sb.fwd_sel[gi*SELW +: SELW] = w_sel;
    end
  endgenerate

  assign w_md_busy = (r_md_cnt != '0);
  assign w_md_hz   = w_md_busy & sb.issue_valid & (sb.issue_md | (|w_port_hilo));
  assign w_stall   = sb.issue_valid & ((|w_port_hz) | w_md_hz) & ~sb.flush;
  assign w_accept  = sb.issue_valid & ~w_stall & ~sb.flush;
  assign w_load    = w_accept & (sb.issue_dst != 7'd0);

  assign sb.stall   = w_stall;
  assign sb.md_busy = w_md_busy;

  always_ff @(posedge clk) begin
    if (reset || sb.flush) begin
      for (int k = 1; k <= DEPTH; k++) begin
        r_valid[k] <= 1'b0;
        r_ura[k]   <= '0;
        r_tnew[k]  <= '0;
      end
    end else begin
      r_valid[1] <= w_load;
      r_ura[1]   <= w_load ? sb.issue_dst : 7'd0;
      r_tnew[1]  <= w_load ? sb.issue_tnew : '0;
      // Latency only counts down once the writer leaves E.
      for (int k = 2; k <= DEPTH; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_ura[k]   <= r_ura[k-1];
        r_tnew[k]  <= (r_tnew[k-1] != '0) ? (r_tnew[k-1] - TW'(1)) : '0;
      end
    end
  end

  // A flush leaves an in-flight multiply/divide running.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_md_cnt <= '0;
    end else if (sb.issue_md_start && w_accept) begin
      r_md_cnt <= sb.issue_md_div ? MDW'(DIV_LAT) : MDW'(MUL_LAT);
    end else if (r_md_cnt != '0) begin
      r_md_cnt <= r_md_cnt - MDW'(1);
    end
  end
endmodule

// File: tb/tb_ura_hazard_scoreboard.sv
// Randomized + directed bench for ura_hazard_scoreboard with a writer-history
// reference model and a queue-based scoreboard.
module tb_ura_hazard_scoreboard;
  localparam int NR = 2, DEPTH = 3, TW = 3, SELW = 2, MUL_LAT = 5, DIV_LAT = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;

  ura_hazard_scoreboard_if #(.NUM_READ(NR), .TW(TW), .SELW(SELW)) ifc ();

  ura_hazard_scoreboard #(
    .NUM_READ(NR), .DEPTH(DEPTH), .TW(TW),
    .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .SELW(SELW)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .sb   (ifc.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, fl, iv, md, mds, mdd;
    logic [6:0] dst;
    logic [2:0] tnew;
    logic [1:0] rv;
    logic [6:0] ura0, ura1;
    logic [2:0] tuse0, tuse1;
  } stim_t;

  typedef struct {
    int cyc;
    logic stall;
    logic [3:0] fwd;
    logic busy;
  } exp_t;

  typedef struct {
    int cyc;
    logic [6:0] ura;
    int tnew;
  } wr_t;

  exp_t exp_q[$];
  wr_t  wr_q[$];
  int   cyc = 0;
  int   kill_cyc = -1;   // writers accepted at or before this cycle are dead
  int   md_last = -1;    // last cycle in which the MD unit reads busy
  int   checks = 0;
  int   failures = 0;

  function automatic stim_t idle();
    stim_t s;
    s.rst = 0; s.fl = 0; s.iv = 0; s.md = 0; s.mds = 0; s.mdd = 0;
    s.dst = 0; s.tnew = 0; s.rv = 0; s.ura0 = 0; s.ura1 = 0; s.tuse0 = 0; s.tuse1 = 0;
    return s;
  endfunction

  // Youngest live writer of u decides: its stage = age, remaining latency
  // = issued tnew minus the stages spent past E.
  function automatic void eval_port(input logic v, input logic [6:0] u, input int tuse,
                                    output logic hz, output logic [1:0] sel);
    int best_age = 0;
    int best_tnew = 0;
    int age, rem;
    hz = 1'b0;
    sel = 2'd0;
    if (!v || u == 7'd0) return;
    foreach (wr_q[j]) begin
      age = cyc - wr_q[j].cyc;
      if (wr_q[j].cyc > kill_cyc && age >= 1 && age <= DEPTH && wr_q[j].ura == u &&
          (best_age == 0 || age < best_age)) begin
        best_age  = age;
        best_tnew = wr_q[j].tnew;
      end
    end
    if (best_age != 0) begin
      rem = best_tnew - (best_age - 1);
      if (rem < 0) rem = 0;
      if (rem > tuse) hz = 1'b1;
      else if (rem == 0) sel = 2'(best_age);
    end
  endfunction

  task automatic drive(input stim_t s);
    logic hz0, hz1, hilo, busy, mdh, st;
    logic [1:0] sel0, sel1;
    exp_t e;
    @(posedge clk);
    #1;
    reset              = s.rst;
    ifc.flush          = s.fl;
    ifc.issue_valid    = s.iv;
    ifc.issue_dst      = s.dst;
    ifc.issue_tnew     = s.tnew;
    ifc.issue_md       = s.md;
    ifc.issue_md_start = s.mds;
    ifc.issue_md_div   = s.mdd;
    ifc.rd_valid       = s.rv;
    ifc.rd_ura         = {s.ura1, s.ura0};
    ifc.rd_tuse        = {s.tuse1, s.tuse0};

    while (wr_q.size() > 0 && (cyc - wr_q[0].cyc) > DEPTH) void'(wr_q.pop_front());
    eval_port(s.rv[0], s.ura0, int'(s.tuse0), hz0, sel0);
    eval_port(s.rv[1], s.ura1, int'(s.tuse1), hz1, sel1);
    hilo = (s.rv[0] && s.ura0[6:5] == 2'b10) || (s.rv[1] && s.ura1[6:5] == 2'b10);
    busy = (cyc <= md_last);
    mdh  = busy && s.iv && (s.md || hilo);
    st   = s.iv && (hz0 || hz1 || mdh) && !s.fl;
    e.cyc = cyc; e.stall = st; e.fwd = {sel1, sel0}; e.busy = busy;
    exp_q.push_back(e);

    if (s.rst) begin
      kill_cyc = cyc;
      md_last  = cyc;
    end else begin
      if (s.fl) kill_cyc = cyc;
      if (s.iv && !st && !s.fl) begin
        if (s.dst != 7'd0) wr_q.push_back('{cyc, s.dst, int'(s.tnew)});
        if (s.mds) md_last = cyc + (s.mdd ? DIV_LAT : MUL_LAT);
      end
    end
    cyc++;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks += 3;
        if (ifc.stall !== e.stall) begin
          failures++;
          $display("FAIL stall cyc=%0d got=%0b want=%0b", e.cyc, ifc.stall, e.stall);
        end
        if (ifc.fwd_sel !== e.fwd) begin
          failures++;
          $display("FAIL fwd_sel cyc=%0d got=%h want=%h", e.cyc, ifc.fwd_sel, e.fwd);
        end
        if (ifc.md_busy !== e.busy) begin
          failures++;
          $display("FAIL md_busy cyc=%0d got=%0b want=%0b", e.cyc, ifc.md_busy, e.busy);
        end
        $display("txn cyc=%0d stall=%0b fwd=%h busy=%0b", e.cyc, ifc.stall, ifc.fwd_sel, ifc.md_busy);
      end
    end
  end

  function automatic logic [6:0] pick_ura();
    case ($urandom_range(0, 7))
      0: return 7'h00;
      1: return 7'h08;
      2: return 7'h09;
      3: return 7'h0A;
      4: return 7'h41;
      5: return 7'h40;
      6: return 7'h61;
      default: return 7'h1F;
    endcase
  endfunction

  initial begin
    stim_t s;
    ifc.flush = 0; ifc.issue_valid = 0; ifc.issue_dst = 0; ifc.issue_tnew = 0;
    ifc.issue_md = 0; ifc.issue_md_start = 0; ifc.issue_md_div = 0;
    ifc.rd_valid = 0; ifc.rd_ura = 0; ifc.rd_tuse = 0;
    repeat (2) @(posedge clk);

    // Reset state, then idle.
    s = idle(); s.rst = 1; drive(s);
    repeat (5) drive(idle());

    // tnew=1 producer: one stall, then forward from M.
    s = idle(); s.iv = 1; s.dst = 7'h08; s.tnew = 1; drive(s);
    s = idle(); s.iv = 1; s.rv = 2'b01; s.ura0 = 7'h08; s.tuse0 = 0; drive(s);
    drive(s);
    repeat (3) drive(idle());

    // tnew=0 producer forwards from E; $0 never matches.
    s = idle(); s.iv = 1; s.dst = 7'h08; s.tnew = 0; drive(s);
    s = idle(); s.iv = 1; s.rv = 2'b01; s.ura0 = 7'h08; drive(s);
    s = idle(); s.iv = 1; s.dst = 7'h00; drive(s);
    s = idle(); s.iv = 1; s.rv = 2'b11; s.ura0 = 7'h00; s.ura1 = 7'h00; drive(s);
    repeat (3) drive(idle());

    // Duplicate writers: youngest wins.
    s = idle(); s.iv = 1; s.dst = 7'h09; drive(s);
    drive(s);
    s = idle(); s.iv = 1; s.rv = 2'b10; s.ura1 = 7'h09; drive(s);
    repeat (3) drive(idle());

    // Divide window, mflo reads stall through it; then a multiply.
    s = idle(); s.iv = 1; s.md = 1; s.mds = 1; s.mdd = 1; drive(s);
    s = idle(); s.iv = 1; s.rv = 2'b01; s.ura0 = 7'h41; repeat (11) drive(s);
    s = idle(); s.iv = 1; s.md = 1; s.mds = 1; s.mdd = 0; drive(s);
    repeat (7) drive(idle());

    // Flush with entries in E/M mid-divide; MD counter keeps running.
    s = idle(); s.iv = 1; s.md = 1; s.mds = 1; s.mdd = 1; s.dst = 7'h40; drive(s);
    repeat (2) drive(idle());
    s = idle(); s.iv = 1; s.dst = 7'h0B; s.tnew = 2; drive(s);
    s = idle(); s.iv = 1; s.dst = 7'h0C; s.tnew = 1; drive(s);
    s = idle(); s.iv = 1; s.fl = 1; s.rv = 2'b01; s.ura0 = 7'h0C; drive(s);
    s = idle(); s.iv = 1; s.rv = 2'b11; s.ura0 = 7'h0C; s.ura1 = 7'h0B; drive(s);
    repeat (2) drive(idle());

    // Reset mid-divide.
    s = idle(); s.iv = 1; s.md = 1; s.mds = 1; s.mdd = 1; drive(s);
    repeat (2) drive(idle());
    s = idle(); s.rst = 1; drive(s);
    repeat (2) drive(idle());

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      s = idle();
      s.iv    = ($urandom_range(0, 9) < 7);
      s.dst   = pick_ura();
      s.tnew  = 3'($urandom_range(0, 4));
      s.md    = ($urandom_range(0, 9) == 0);
      s.mds   = s.md && ($urandom_range(0, 1) == 1);
      s.mdd   = 1'($urandom_range(0, 1));
      s.rv    = 2'($urandom_range(0, 3));
      s.ura0  = pick_ura();
      s.ura1  = pick_ura();
      s.tuse0 = 3'($urandom_range(0, 3));
      s.tuse1 = 3'($urandom_range(0, 3));
      s.fl    = ($urandom_range(0, 24) == 0);
      s.rst   = ($urandom_range(0, 99) == 0);
      drive(s);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ura_hazard_scoreboard.md
Name: ura_hazard_scoreboard

Overview:
- Parametrised hazard and forwarding unit for the D stage, keyed on the 7-bit Unified Register Address (URA).
- URA layout: [6:5] group (00 GRF, 01 CP0, 10 HI/LO, 11 reserved); [4:0] register select.
- Tracks in-flight destination URAs through DEPTH downstream stages, each with a remaining-latency counter (Tnew).
- Evaluates NUM_READ source operands per cycle, tracks the multi-cycle multiply/divide busy window, and produces stall and per-operand forward-select outputs.

Parameters:
- NUM_READ, 2, number of source-operand ports checked per cycle.
- DEPTH, 3, number of tracked stages after D (1=E, 2=M, 3=W).
- TW, 3, width of Tnew/Tuse fields.
- MUL_LAT, 5, busy cycles after a multiply start.
- DIV_LAT, 10, busy cycles after a divide start.
- SELW, 2, forward-select width; must satisfy 2^SELW > DEPTH.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- issue_valid  in  1  D-stage instruction wants to advance to E.
- issue_dst  in  7  destination URA of the D instruction.
- issue_tnew  in  TW  cycles after entering E until the result is forwardable.
- issue_md  in  1  D instruction uses the multiply unit (mult/div/mthi/mtlo).
- issue_md_start  in  1  D instruction starts a multi-cycle operation.
- issue_md_div  in  1  with issue_md_start: 1=divide, 0=multiply.
- rd_valid  in  NUM_READ  per-port operand used.
- rd_ura  in  NUM_READ*7  per-port source URA; port i at [7i+6:7i].
- rd_tuse  in  NUM_READ*TW  per-port cycles from D until the value is needed.
- flush  in  1  synchronous kill of all tracked entries.
- stall  out  1  freeze PC/D; bubble into E.
- fwd_sel  out  NUM_READ*SELW  per port: 0 = register file, k = forward from stage k.
- md_busy  out  1  multiply unit occupied.

Behaviour:
- State:
  - entry[1..DEPTH], each {valid, ura[6:0], tnew[TW-1:0]}.
  - md_cnt, width clog2(DIV_LAT+1).
- Reset: all entry.valid=0, ura=0, tnew=0; md_cnt=0.
  - Outputs are combinational from state and inputs; with reset asserted and state empty: stall=0, fwd_sel=0, md_busy=0.
- Port match: port i matches entry k iff rd_valid[i] & entry[k].valid & entry[k].ura==rd_ura[i] & rd_ura[i]!=7'b0000000. GRF $0 never matches.
- Youngest rule: only the lowest-k matching entry is considered.
  - tnew > rd_tuse[i]: data hazard on port i.
  - Else, tnew==0: fwd_sel[i]=k.
  - Else: fwd_sel[i]=0 (a later stage forwards).
- No match: fwd_sel[i]=0.
- md_busy = (md_cnt!=0).
- MD hazard: md_busy & issue_valid & (issue_md | any valid port with rd_ura[6:5]==2'b10).
- stall = issue_valid & (any port data hazard | MD hazard) & !flush.
- Advance each cycle, unless reset:
  - entry[k] <= entry[k-1] for k=2..DEPTH; tnew decrements, saturating at 0.
  - entry[DEPTH] is discarded.
- entry[1] loads:
  - {1, issue_dst, issue_tnew} if issue_valid & !stall & !flush & issue_dst!=0.
  - Otherwise invalid, with ura and tnew cleared.
- Tnew: issue_tnew is stored undecremented into entry[1]. It decrements only on moves into entry[2..DEPTH].
- md_cnt priority:
  - reset → 0.
  - issue_md_start & issue_valid & !stall & !flush → DIV_LAT if issue_md_div, else MUL_LAT.
  - md_cnt!=0 → md_cnt-1.
- flush:
  - Clears entry[1..DEPTH] (all valid=0) at the next edge.
  - Blocks issue in that cycle and forces stall=0.
  - md_cnt is NOT cleared; an in-flight multiply/divide completes.
- Simultaneous events:
  - Reset dominates flush and issue.
  - A match in entry[1] with tnew==0 forwards from E in the same cycle.
  - Duplicate URAs in the pipeline are resolved by the youngest rule.
- Group 11 URAs are tracked and compared like any other group; no special case.

Test Plan:
- Reset, then idle 5 cycles → stall=0, fwd_sel=0, md_busy=0, all entries invalid.
- Issue dst=7'h08 tnew=1, next cycle read rd_ura=7'h08 tuse=0 → stall=1 for one cycle (bubble enters E). Following cycle the entry sits in M with tnew=0 → stall=0, fwd_sel=2.
- Issue dst=7'h08 tnew=0, next cycle read 7'h08 tuse=0 → stall=0, fwd_sel=1. Read rd_ura=7'h00 with a 7'h00 entry present → fwd_sel=0, stall=0.
- Two in-flight writers of 7'h09 (M tnew=0, E tnew=0), read 7'h09 → fwd_sel=1 (youngest wins).
- Divide start (DIV_LAT=10) → md_busy=1 for exactly 10 cycles. mflo (rd_ura=7'h41) during the window → stall=1. Same read on cycle 11 → stall=0. Multiply start → 5 busy cycles.
- Entries in E/M, md_cnt=6, assert flush with issue_valid=1 → stall=0. Next cycle all entries invalid, md_cnt=5. Assert reset mid-divide → md_busy=0 next cycle.
